xaddr_periph_bus: RTL
=====================

XADDR_PERIPH_BUS -- requirements
Module: xaddr_periph_bus

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 12: width of the external address.
REQ-002 The block SHALL have parameter DATA_W, default 32: width of the read data.
REQ-003 The block SHALL have parameter BASE, default 0: peripheral window base address; offset = addr - BASE.
REQ-004 The block SHALL have parameter SW_W, default 7: switch count.
REQ-005 The block SHALL have parameter BTN_W, default 4: button count.
REQ-006 The block SHALL have parameter RND_W, default 3: random-source width.
REQ-007 The block SHALL have parameter N_DISP, default 4: display-digit select count, 1..8.

Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port clk, input, 1: the single clock; everything is on the rising edge.
REQ-009 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-010 The block SHALL have ports addr input ADDR_W, rd_en input 1 and wr_en input 1: the CPU access.
REQ-011 The block SHALL have ports switch_in input SW_W, button_in input BTN_W and lfsr_in input RND_W: raw, asynchronous board or peripheral inputs.
REQ-012 The block SHALL have ports data_out output DATA_W and rd_valid output 1: registered read data and its qualifier.
REQ-013 The block SHALL have ports led_sel output 1 and display_sel output N_DISP: one-hot, combinational write strobes.
REQ-014 The block SHALL have port bus_err output 1: sticky error flag for illegal accesses.

Function
REQ-015 The offset map SHALL be:
- 0 = LED (write only)
- 1 = SWITCH (read only)
- 2 = BUTTON level (read only)
- 3 = BUTTON events (read only, clear-on-read)
- 4 = LFSR (read only)
- 5 = STATUS (read only: bit0 = bus_err, clear-on-read)
- 8..8+N_DISP-1 = DISPLAY0..N (write only)
- all other offsets are unmapped.
REQ-016 led_sel and display_sel[k] SHALL equal wr_en AND the address match, combinationally, with zero latency and at most one bit high.
REQ-017 switch_in and button_in SHALL each pass through a 2-flop synchronizer before any use; lfsr_in SHALL be sampled directly.
REQ-018 An event bit SHALL be set on the clock where the synchronized button goes 0->1 (rising edge relative to its previous synchronized value).
REQ-019 Event bits SHALL remain set until cleared by a read of offset 3.
REQ-020 A read (rd_en high, mapped readable offset) SHALL load data_out on the next rising edge and assert rd_valid for exactly that one cycle: 1-cycle latency.
REQ-021 Read data SHALL be zero-extended to DATA_W.
REQ-022 When no valid read occurs, data_out SHALL hold its last value and rd_valid SHALL be 0.
REQ-023 A read of offset 3 SHALL return the event register, then clear it on the same edge that loads data_out.
REQ-024 If a new edge arrives on that same edge, the new edge's bit SHALL remain set; set wins over clear for that bit.
REQ-025 A read of offset 5 SHALL return the bus_err value and clear it on the same edge.
REQ-026 If a new error occurs on that same edge, bus_err SHALL remain 1.
REQ-027 bus_err SHALL set on the edge after any of:
- rd_en or wr_en to an unmapped offset;
- wr_en to a read-only offset;
- rd_en to a write-only offset;
- rd_en and wr_en both high.
REQ-028 An illegal access SHALL produce no strobe and rd_valid = 0.
REQ-029 When rd_en and wr_en are both high, write strobes SHALL be suppressed.
REQ-030 Addresses below BASE SHALL be unmapped; offset arithmetic SHALL NOT wrap into the window.

Reset
REQ-031 While rst is high at a clock edge, the following SHALL go to 0:
- data_out and rd_valid;
- bus_err;
- the event register;
- all synchronizer and previous-value flops.
REQ-032 While rst is high, strobes SHALL be forced to 0 regardless of wr_en.
REQ-033 A read issued in the cycle rst is asserted SHALL be discarded: rd_valid = 0 on the following cycle.
REQ-034 No button edge SHALL be detected on the first cycles after reset for buttons already held, since previous values reset to 0 and then follow the synchronizer. The first edge is detected only once the synchronized level rises from its reset value of 0.

Verification
REQ-035 The bench SHALL cover: wr_en=1 with addr=BASE+9 -> display_sel=4'b0010 in the same cycle; led_sel=0; bus_err stays 0.
REQ-036 The bench SHALL cover: switch_in=7'h55 held 3 cycles, then read offset 1 -> the next cycle gives rd_valid=1 and data_out=32'h55; the cycle after gives rd_valid=0 with data_out held.
REQ-037 The bench SHALL cover: pulse button_in[2] high for 4 cycles then low, read offset 3 -> data_out=4'b0100. A second read returns 0.
REQ-038 The bench SHALL cover: a button edge coinciding with the offset-3 read edge -> the returned data excludes or includes it per sync timing, and the bit is set after the read.
REQ-039 The bench SHALL cover: wr_en to offset 1, then read offset 5 -> data_out=1 and bus_err falls to 0; rd_en+wr_en to offset 0 -> no led_sel and bus_err=1.
REQ-040 The bench SHALL cover: rst asserted in the same cycle as a read of offset 4 -> rd_valid stays 0; all outputs are 0 after the reset cycle.

Source files
------------

// File: rtl/xaddr_periph_bus.sv
// Peripheral address decoder: registered reads of switches, buttons, LFSR and status,
// combinational one-hot write strobes for LED and display digits, sticky bus error.
module xaddr_periph_bus #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int BASE   = 0,
    parameter int SW_W   = 7,
    parameter int BTN_W  = 4,
    parameter int RND_W  = 3,
    parameter int N_DISP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [SW_W-1:0]   switch_in,
    input  logic [BTN_W-1:0]  button_in,
    input  logic [RND_W-1:0]  lfsr_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              led_sel,
    output logic [N_DISP-1:0] display_sel,
    output logic              bus_err
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    logic [ADDR_W-1:0] offset;
    logic              in_win;
    logic              is_led, is_sw, is_btn, is_evt, is_lfsr, is_stat, is_disp;
    logic              readable, writable, mapped;
    logic              rd_ok, wr_ok, illegal;

    logic [SW_W-1:0]   sw_s1, sw_s2;
    logic [BTN_W-1:0]  btn_s1, btn_s2, btn_prev;
    logic [BTN_W-1:0]  btn_evt, btn_rise;

    // Addresses below BASE never alias into the window through subtraction wrap.
    assign in_win = (addr >= BASE_A);
    assign offset = addr - BASE_A;

    always_comb begin
        is_led   = in_win && (offset == ADDR_W'(0));
        is_sw    = in_win && (offset == ADDR_W'(1));
        is_btn   = in_win && (offset == ADDR_W'(2));
        is_evt   = in_win && (offset == ADDR_W'(3));
        is_lfsr  = in_win && (offset == ADDR_W'(4));
        is_stat  = in_win && (offset == ADDR_W'(5));
        is_disp  = in_win && (offset >= ADDR_W'(8)) && (offset < ADDR_W'(8 + N_DISP));
        readable = is_sw || is_btn || is_evt || is_lfsr || is_stat;
        writable = is_led || is_disp;
        mapped   = readable || writable;
        rd_ok    = rd_en && !wr_en && readable && !rst;
        wr_ok    = wr_en && !rd_en && writable && !rst;
        illegal  = (rd_en || wr_en) &&
                   (!mapped || (wr_en && !writable) || (rd_en && !readable) || (rd_en && wr_en));
    end

    always_comb begin
        led_sel     = wr_ok && is_led;
        display_sel = '0;
        for (int k = 0; k < N_DISP; k++) begin
            display_sel[k] = wr_ok && is_disp && (offset == ADDR_W'(8 + k));
        end
    end

    assign btn_rise = btn_s2 & ~btn_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            btn_evt  <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            sw_s1    <= switch_in;
            sw_s2    <= sw_s1;
            btn_s1   <= button_in;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            rd_valid <= rd_ok;

            // A fresh rising edge survives a clear-on-read on the same clock.
            if (rd_ok && is_evt) btn_evt <= btn_rise;
            else                 btn_evt <= btn_evt | btn_rise;

            if (illegal)                bus_err <= 1'b1;
            else if (rd_ok && is_stat)  bus_err <= 1'b0;

            if (rd_ok) begin
                if (is_sw)        data_out <= DATA_W'(sw_s2);
                else if (is_btn)  data_out <= DATA_W'(btn_s2);
                else if (is_evt)  data_out <= DATA_W'(btn_evt);
                else if (is_lfsr) data_out <= DATA_W'(lfsr_in);
                else              data_out <= DATA_W'(bus_err);
            end
        end
    end

endmodule
